dsc_csc_slice_feeder: RTL and testbench

Upstream input stage of the DSC encoder. Accepts slice-ordered RGB pixels over valid/ready and applies the DSC YCoCg-R colour-space conversion, or passes RGB through. Tags each output pixel with slice-position flags (start of slice, end of line, end of slice) derived from the runtime slice geometry, for the encoder core. Detects misaligned slice starts and resynchronises to them.

---
 rtl/dsc_csc_slice_feeder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_dsc_csc_slice_feeder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dsc_csc_slice_feeder.sv
// dsc_csc_slice_feeder
//   Input stage of the DSC encoder. Accepts slice-ordered RGB pixels over
//   valid/ready, converts them to YCoCg-R (or passes RGB through), and tags
//   each pixel with start-of-slice / end-of-line / end-of-slice flags derived
//   from the slice geometry latched at the start of each slice. Misaligned
//   slice starts raise a sticky error and resynchronise the position counters.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   cfg_slice_width/height      slice geometry (>=1), latched on slice start
//   cfg_csc_en                  1 = YCoCg-R, 0 = RGB passthrough
//   in_valid/in_ready/in_sos    input handshake and slice-start marker
//   in_rgb                      {R,G,B}, R in MSBs
//   out_valid/out_ready         output handshake
//   out_c0/c1/c2                Y/Co/Cg (offset) or zero-extended R/G/B
//   out_sos/out_eol/out_eos     position tags
//   err_sos                     sticky misaligned-slice-start flag
//
// Build option
//   DSC_CSC_BYPASS_EN : removes the colour converter; outputs are always
//                       zero-extended RGB, latency unchanged.
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a pixel with in_sos; other pixels are dropped
//   ACTIVE | inside a slice, counting x/y

module dsc_csc_slice_feeder #(
  parameter int BPC   = 8,
  parameter int DIM_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIM_W-1:0]   cfg_slice_width,
  input  logic [DIM_W-1:0]   cfg_slice_height,
  input  logic               cfg_csc_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sos,
  input  logic [3*BPC-1:0]   in_rgb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BPC:0]       out_c0,
  output logic [BPC:0]       out_c1,
  output logic [BPC:0]       out_c2,
  output logic               out_sos,
  output logic               out_eol,
  output logic               out_eos,
  output logic               err_sos
);

  localparam int IW = BPC + 2;
  localparam logic [BPC:0] OFS = {1'b1, {BPC{1'b0}}};

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   x_q, x_d, y_q, y_d;
  logic [DIM_W-1:0]   w_q, h_q, w_eff, h_eff;
  logic [DIM_W-1:0]   x_cur, y_cur;
  logic               csc_q, csc_eff, csc_sel;
  logic               rdy_q;
  logic               accept, load, keep, err_set;
  logic               tag_sos, tag_eol, tag_eos;

  logic               s1_valid, s2_valid, s1_en, s2_en;
  logic signed [IW-1:0] s1_a, s1_b;
  logic [BPC-1:0]     s1_g;
  logic               s1_csc, s1_sos, s1_eol, s1_eos;

  logic [BPC:0]       s2_c0, s2_c1, s2_c2;
  logic               s2_sos, s2_eol, s2_eos;
  logic [BPC:0]       c0_d, c1_d, c2_d;

  logic [BPC-1:0]     r_in, g_in, b_in;
  logic signed [IW-1:0] a_in, b_val;

  assign {r_in, g_in, b_in} = in_rgb;

  // Handshake: stage 2 frees when empty or draining; stage 1 frees when empty
  // or moving into stage 2. rdy_q keeps in_ready low through reset.
  assign s2_en    = !s2_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = rdy_q && s1_en;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      csc_q   <= 1'b0;
      err_sos <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rdy_q   <= 1'b1;
      if (err_set) err_sos <= 1'b1;
      if (load) begin
        w_q   <= cfg_slice_width;
        h_q   <= cfg_slice_height;
        csc_q <= cfg_csc_en;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    load    = 1'b0;
    keep    = 1'b0;
    err_set = 1'b0;
    x_cur   = x_q;
    y_cur   = y_q;
    w_eff   = w_q;
    h_eff   = h_q;
    csc_eff = csc_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sos) begin
            load = 1'b1;
            keep = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (accept) begin
          keep = 1'b1;
          if (in_sos) begin
            load = 1'b1;
            if ((x_q != '0) || (y_q != '0)) err_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A slice start uses the live config for its own tags, since the shadow
    // registers only update on the accepting edge.
    if (load) begin
      x_cur   = '0;
      y_cur   = '0;
      w_eff   = cfg_slice_width;
      h_eff   = cfg_slice_height;
      csc_eff = cfg_csc_en;
    end

    tag_sos = (x_cur == '0) && (y_cur == '0);
    tag_eol = (x_cur == (w_eff - DIM_W'(1)));
    tag_eos = tag_eol && (y_cur == (h_eff - DIM_W'(1)));

    if (keep) begin
      state_d = ACTIVE;
      if (tag_eol) begin
        x_d = '0;
        if (tag_eos) begin
          y_d     = '0;
          state_d = IDLE;
        end else begin
          y_d = y_cur + DIM_W'(1);
        end
      end else begin
        x_d = x_cur + DIM_W'(1);
        y_d = y_cur;
      end
    end
  end

`ifdef DSC_CSC_BYPASS_EN
  logic unused_cfg;
  assign unused_cfg = csc_eff;
  assign csc_sel    = 1'b0;
  assign a_in       = $signed({2'b00, r_in});
  assign b_val      = $signed({2'b00, b_in});
`else
  logic signed [IW-1:0] co_c, t_c;
  assign co_c    = $signed({2'b00, r_in}) - $signed({2'b00, b_in});
  assign t_c     = $signed({2'b00, b_in}) + (co_c >>> 1);
  assign csc_sel = csc_eff;
  // Stage 1 carries co/t when converting, raw R/B otherwise.
  assign a_in    = csc_sel ? co_c : $signed({2'b00, r_in});
  assign b_val   = csc_sel ? t_c  : $signed({2'b00, b_in});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_g     <= '0;
      s1_csc   <= 1'b0;
      s1_sos   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eos   <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= keep;
      if (keep) begin
        s1_a   <= a_in;
        s1_b   <= b_val;
        s1_g   <= g_in;
        s1_csc <= csc_sel;
        s1_sos <= tag_sos;
        s1_eol <= tag_eol;
        s1_eos <= tag_eos;
      end
    end
  end

`ifdef DSC_CSC_BYPASS_EN
  logic unused_bits;
  assign unused_bits = ^{s1_a[IW-1:BPC+1], s1_b[IW-1:BPC+1], s1_csc};
  assign c0_d = s1_a[BPC:0];
  assign c1_d = {1'b0, s1_g};
  assign c2_d = s1_b[BPC:0];
`else
  logic signed [IW-1:0] cg_c, y_c;
  logic unused_bits;
  assign cg_c = $signed({2'b00, s1_g}) - s1_b;
  assign y_c  = s1_b + (cg_c >>> 1);
  // Offsets are applied modulo 2^(BPC+1): the top intermediate bit is just sign.
  assign unused_bits = ^{s1_a[IW-1], y_c[IW-1], cg_c[IW-1]};
  assign c0_d = s1_csc ? y_c[BPC:0]          : s1_a[BPC:0];
  assign c1_d = s1_csc ? (s1_a[BPC:0] + OFS) : {1'b0, s1_g};
  assign c2_d = s1_csc ? (cg_c[BPC:0] + OFS) : s1_b[BPC:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_c0    <= '0;
      s2_c1    <= '0;
      s2_c2    <= '0;
      s2_sos   <= 1'b0;
      s2_eol   <= 1'b0;
      s2_eos   <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c0  <= c0_d;
        s2_c1  <= c1_d;
        s2_c2  <= c2_d;
        s2_sos <= s1_sos;
        s2_eol <= s1_eol;
        s2_eos <= s1_eos;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_c0    = s2_c0;
  assign out_c1    = s2_c1;
  assign out_c2    = s2_c2;
  assign out_sos   = s2_sos;
  assign out_eol   = s2_eol;
  assign out_eos   = s2_eos;

endmodule

// File: tb/tb_dsc_csc_slice_feeder.sv
module tb_dsc_csc_slice_feeder;

  typedef struct packed {
    logic [8:0] c0;
    logic [8:0] c1;
    logic [8:0] c2;
    logic       sos;
    logic       eol;
    logic       eos;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_w, cfg_h;
  logic        cfg_csc;
  logic        in_valid, in_ready, in_sos;
  logic [23:0] in_rgb;
  logic        out_valid, out_ready;
  logic [8:0]  out_c0, out_c1, out_c2;
  logic        out_sos, out_eol, out_eos, err_sos;

  int   total = 0;
  int   bad   = 0;
  bit   bp    = 1'b0;
  pix_t q[$];

  always #5 clk = ~clk;

  dsc_csc_slice_feeder #(.BPC(8), .DIM_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_slice_width(cfg_w), .cfg_slice_height(cfg_h), .cfg_csc_en(cfg_csc),
    .in_valid(in_valid), .in_ready(in_ready), .in_sos(in_sos), .in_rgb(in_rgb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2),
    .out_sos(out_sos), .out_eol(out_eol), .out_eos(out_eos), .err_sos(err_sos)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pix_t model(input int r, input int g, input int b, input bit csc,
                                 input bit s, input bit e, input bit f);
    pix_t p;
    int co, t, cg, yy;
    if (csc) begin
      co = r - b;
      t  = b + (co >>> 1);
      cg = g - t;
      yy = t + (cg >>> 1);
      p.c0 = yy[8:0];
      p.c1 = 9'(co + 256);
      p.c2 = 9'(cg + 256);
    end else begin
      p.c0 = r[8:0];
      p.c1 = g[8:0];
      p.c2 = b[8:0];
    end
    p.sos = s; p.eol = e; p.eos = f;
    return p;
  endfunction

  // Drive one pixel; push its expected output when it is seen to be accepted.
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input bit sos, input bit keep, input pix_t e);
    bit ok;
    int guard = 0;
    in_valid = 1'b1;
    in_sos   = sos;
    in_rgb   = {r, g, b};
    forever begin
      @(negedge clk);
      ok = in_ready;
      if (ok && keep) q.push_back(e);
      @(posedge clk); #1;
      if (bp) out_ready = 1'($urandom_range(0, 1));
      if (ok) break;
      guard++;
      if (guard > 200) begin
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    in_sos   = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
  endtask

  // Output monitor: scoreboard pop on every transfer, hold check during stalls.
  pix_t got, held, ex;
  bit   stall_prev = 1'b0;
  always @(negedge clk) begin
    got = {out_c0, out_c1, out_c2, out_sos, out_eol, out_eos};
    if (rst_n) begin
      if (stall_prev) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {2'b0, got}, {2'b0, held});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          ex = q.pop_front();
          chk("pixel", {2'b0, got}, {2'b0, ex});
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = got;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    logic [7:0] r, g, b;
    bit s, e, f;
    int j;
    rst_n = 1'b0; in_valid = 1'b0; in_sos = 1'b0; in_rgb = '0;
    out_ready = 1'b1; cfg_w = 16'd1; cfg_h = 16'd1; cfg_csc = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {5'd0, out_c0, out_c1, out_c2}, 32'd0);
    chk("rst_tags", {29'd0, out_sos, out_eol, out_eos}, 32'd0);
    chk("rst_err", {31'd0, err_sos}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Single-pixel slices, W=H=1
    send(8'd255, 8'd0, 8'd0, 1'b1, 1'b1, '{9'd63, 9'd511, 9'd129, 1'b1, 1'b1, 1'b1});
    @(negedge clk);
    chk("latency_c1", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_c2", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    send(8'd255, 8'd255, 8'd255, 1'b1, 1'b1, '{9'd255, 9'd256, 9'd256, 1'b1, 1'b1, 1'b1});
    send(8'd0, 8'd0, 8'd0, 1'b1, 1'b1, '{9'd0, 9'd256, 9'd256, 1'b1, 1'b1, 1'b1});
    cfg_csc = 1'b0;
    send(8'd1, 8'd2, 8'd3, 1'b1, 1'b1, '{9'd1, 9'd2, 9'd3, 1'b1, 1'b1, 1'b1});
    drain();
    chk("err_clean_1", {31'd0, err_sos}, 32'd0);

    // W=4,H=2 with random back-pressure
    cfg_w = 16'd4; cfg_h = 16'd2; cfg_csc = 1'b1; bp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom_range(0, 255)); g = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      send(r, g, b, i == 0, 1'b1, model(r, g, b, 1'b1, i == 0, (i % 4) == 3, i == 7));
    end
    bp = 1'b0; out_ready = 1'b1;
    drain();
    chk("err_clean_2", {31'd0, err_sos}, 32'd0);

    // Misaligned slice start at pixel 5
    for (int i = 0; i < 13; i++) begin
      r = 8'($urandom_range(0, 255)); g = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      if (i < 5) begin
        s = (i == 0); e = (i == 3); f = 1'b0;
      end else begin
        j = i - 5;
        s = (j == 0); e = (j % 4) == 3; f = (j == 7);
      end
      send(r, g, b, (i == 0) || (i == 5), 1'b1, model(r, g, b, 1'b1, s, e, f));
      if (i == 4) chk("err_before_mis", {31'd0, err_sos}, 32'd0);
    end
    drain();
    chk("err_misaligned", {31'd0, err_sos}, 32'd1);

    // Reset with two pixels in flight
    out_ready = 1'b0;
    send(8'd9, 8'd9, 8'd9, 1'b1, 1'b0, '0);
    send(8'd7, 8'd7, 8'd7, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_err", {31'd0, err_sos}, 32'd0);
    cfg_w = 16'd1; cfg_h = 16'd1;
    send(8'd10, 8'd20, 8'd30, 1'b1, 1'b1, model(10, 20, 30, 1'b1, 1'b1, 1'b1, 1'b1));
    drain();

    // Pixels without in_sos while idle are dropped
    for (int i = 0; i < 3; i++) send(8'(i), 8'd5, 8'd6, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drop_no_out", {31'd0, out_valid}, 32'd0);
    end
    chk("drop_err", {31'd0, err_sos}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
